button_debouncer: RTL and testbench
===================================

BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
REQ-001 Parameter WIDTH, default 4, number of independent input channels.
REQ-002 Parameter CNT_MAX, default 1_000_000, stable-sample count before a level change is accepted (20 ms at 50 MHz).
REQ-003 Parameter ACTIVE_LOW, default 1; when 1 a raw 0 means "pressed".
REQ-004 Parameter REPEAT_DLY, default 25_000_000, hold cycles before the first auto-repeat pulse (used only with the macro).
REQ-005 Parameter REPEAT_PER, default 5_000_000, cycles between later auto-repeat pulses (used only with the macro).
REQ-006 clk  input  1  system clock, 50 MHz domain.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 raw_i  input  WIDTH  asynchronous raw button/switch pins.
REQ-009 level_o  output  WIDTH  debounced level per channel, 1 = pressed, polarity-normalised.
REQ-010 press_o  output  WIDTH  one-cycle pulse per accepted press, plus auto-repeat pulses when enabled.
REQ-011 release_o  output  WIDTH  one-cycle pulse per accepted release.

Function
REQ-012 Each raw_i bit SHALL pass a 2-flop synchroniser; when ACTIVE_LOW=1 it SHALL be inverted after synchronisation.
REQ-013 Each channel SHALL hold a counter of width clog2(CNT_MAX+1); the counter clears whenever the synchronised sample equals level_o.
REQ-014 While the sample differs from level_o the counter SHALL increment by 1 per cycle; on the cycle it would reach CNT_MAX, level_o SHALL toggle and the counter SHALL clear.
REQ-015 Latency: a raw change held stable SHALL appear on level_o exactly CNT_MAX+2 rising edges after the first edge that samples it.
REQ-016 A glitch shorter than CNT_MAX cycles at the synchroniser output SHALL NOT change level_o, and SHALL restart the count from 0 when the sample returns to level_o.
REQ-017 press_o[i] SHALL be high for exactly the one cycle in which level_o[i] goes 0->1; release_o[i] likewise for 1->0; the two SHALL never be high together on one channel.
REQ-018 Channels SHALL be fully independent; simultaneous transitions on several channels SHALL each produce their own pulses in the same cycle.
REQ-019 The counter SHALL never wrap; it saturates by design at CNT_MAX through REQ-014.
REQ-020 CNT_MAX=1 SHALL be legal and gives level_o = sample delayed one cycle.

Reset
REQ-021 While rst=1: synchroniser flops SHALL load the "released" raw value, counters 0, level_o 0, press_o 0, release_o 0.
REQ-022 Assertion of rst mid-count SHALL discard the partial count; no pulse SHALL be emitted in the cycle following reset release.
REQ-023 A button held through reset SHALL be accepted as a new press CNT_MAX+2 cycles after rst falls.

Configuration
REQ-024 Macro DEBOUNCER_AUTOREPEAT_EN: when defined, each channel SHALL have a repeat counter. While level_o[i]=1 it SHALL emit an extra press_o pulse REPEAT_DLY cycles after the press pulse, then every REPEAT_PER cycles, until release. The counter clears on release or reset.
REQ-025 Without DEBOUNCER_AUTOREPEAT_EN, no repeat logic SHALL be synthesised, REPEAT_DLY and REPEAT_PER SHALL be ignored, and press_o fires once per press.

Structure
REQ-026 Package debounce_pkg SHALL hold the default constants CNT_MAX_20MS=1_000_000, REPEAT_DLY_500MS and REPEAT_PER_100MS, plus a clog2 helper function.
REQ-027 One sub-module, debounce_bit (synchroniser, counter, edge pulses, optional repeat), SHALL be instantiated WIDTH times by a generate loop; the top level holds no other logic.

Verification (CNT_MAX=8, REPEAT_DLY=20, REPEAT_PER=6, WIDTH=4, ACTIVE_LOW=1)
REQ-028 Bench case: hold raw_i[0] low from cycle 10 -> level_o[0]=1 at cycle 20, with press_o[0] a single pulse at cycle 20.
REQ-029 Bench case: pulse raw_i[1] low for 5 cycles, repeat with 3-cycle gaps -> level_o[1] stays 0, and press_o and release_o stay 0.
REQ-030 Bench case: channel 0 pressed, then raw_i[0] high from cycle 40 -> release_o[0] pulses at cycle 50 and level_o[0]=0.
REQ-031 Bench case: all four bits low together -> press_o=4'b1111 for one cycle, then level_o=4'b1111.
REQ-032 Bench case: rst=1 for 2 cycles at count 5 of a press -> outputs 0 during reset; the press is accepted 10 cycles after rst falls, with no spurious pulse at reset release.
REQ-033 Bench case: with DEBOUNCER_AUTOREPEAT_EN, hold for 60 cycles after acceptance -> press_o pulses at +0, +20, +26, +32 ... +56, and stops on release.

Source files
------------

// File: rtl/debounce_pkg.sv
// debounce_pkg: default timing constants and a constant-width helper for the button debouncer.
package debounce_pkg;
   localparam int CNT_MAX_20MS     = 1_000_000;
   localparam int REPEAT_DLY_500MS = 25_000_000;
   localparam int REPEAT_PER_100MS = 5_000_000;
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((64'd1 << r) < 64'(v)) r++;
      return r;
   endfunction
endpackage

// File: rtl/debounce_bit.sv
// debounce_bit: one channel -- 2-flop synchroniser, stability counter, press/release pulses.
// Auto-repeat press pulses exist only when DEBOUNCER_AUTOREPEAT_EN is defined.
module debounce_bit
   import debounce_pkg::*;
#(
   parameter int CNT_MAX    = CNT_MAX_20MS,
   parameter int ACTIVE_LOW = 1,
   parameter int REPEAT_DLY = REPEAT_DLY_500MS,
   parameter int REPEAT_PER = REPEAT_PER_100MS
) (
   input  logic clk,
   input  logic rst,
   input  logic raw_i,
   output logic level_o,
   output logic press_o,
   output logic release_o
);
   localparam int   CW  = clog2(CNT_MAX + 1);
   localparam logic REL = (ACTIVE_LOW != 0);
   logic          s1_q, s2_q, level_q, level_d, press_q, press_d, release_q, release_d;
   logic          smp, hit;
   logic [CW-1:0] cnt_q, cnt_d;
   // hit fires on the cycle the counter would reach CNT_MAX, so it never wraps
   always_comb begin
      smp       = s2_q ^ REL;
      hit       = (smp != level_q) && (cnt_q == CW'(CNT_MAX - 1));
      cnt_d     = (smp == level_q || hit) ? '0 : cnt_q + 1'b1;
      level_d   = level_q ^ hit;
      release_d = hit & level_q;
   end
`ifdef DEBOUNCER_AUTOREPEAT_EN
   localparam int RW = clog2(REPEAT_DLY + 1);
   logic [RW-1:0] rep_q, rep_d;
   logic          rep_hit;
   // after each repeat pulse, rewind so the next one lands REPEAT_PER cycles later
   always_comb begin
      rep_hit = level_q && !hit && (rep_q == RW'(REPEAT_DLY - 1));
      rep_d   = (!level_q || hit) ? '0 : rep_hit ? RW'(REPEAT_DLY - REPEAT_PER) : rep_q + 1'b1;
      press_d = (hit & ~level_q) | rep_hit;
   end
   always_ff @(posedge clk) begin
      rep_q <= rst ? '0 : rep_d;
   end
`else
   logic unused_repeat;
   assign unused_repeat = ^{REPEAT_DLY, REPEAT_PER};
   assign press_d = hit & ~level_q;
`endif
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q      <= REL;
         s2_q      <= REL;
         cnt_q     <= '0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         s1_q      <= raw_i;
         s2_q      <= s1_q;
         cnt_q     <= cnt_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
      end
   end
   assign level_o   = level_q;
   assign press_o   = press_q;
   assign release_o = release_q;
endmodule

// File: rtl/button_debouncer.sv
// button_debouncer: WIDTH independent debounced button channels with press/release pulses.
// Define DEBOUNCER_AUTOREPEAT_EN to add auto-repeat press pulses while a button is held.
module button_debouncer
   import debounce_pkg::*;
#(
   parameter int WIDTH      = 4,
   parameter int CNT_MAX    = CNT_MAX_20MS,
   parameter int ACTIVE_LOW = 1,
   parameter int REPEAT_DLY = REPEAT_DLY_500MS,
   parameter int REPEAT_PER = REPEAT_PER_100MS
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] raw_i,
   output logic [WIDTH-1:0] level_o,
   output logic [WIDTH-1:0] press_o,
   output logic [WIDTH-1:0] release_o
);
   for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      debounce_bit #(
         .CNT_MAX   (CNT_MAX),
         .ACTIVE_LOW(ACTIVE_LOW),
         .REPEAT_DLY(REPEAT_DLY),
         .REPEAT_PER(REPEAT_PER)
      ) u_bit (
         .clk      (clk),
         .rst      (rst),
         .raw_i    (raw_i[i]),
         .level_o  (level_o[i]),
         .press_o  (press_o[i]),
         .release_o(release_o[i])
      );
   end
endmodule

// File: tb/tb_button_debouncer.sv
// tb_button_debouncer: directed cases plus random bouncing, checked against a run-length reference model.
module tb_button_debouncer;
   localparam int W = 4, CM = 8, RD = 20, RP = 6;
   logic         clk = 1'b0, rst = 1'b1;
   logic [W-1:0] raw = '1;
   logic [W-1:0] level_o, press_o, release_o;
   int           n_checks = 0, n_pass = 0;
   button_debouncer #(
      .WIDTH(W), .CNT_MAX(CM), .ACTIVE_LOW(1), .REPEAT_DLY(RD), .REPEAT_PER(RP)
   ) dut (
      .clk(clk), .rst(rst), .raw_i(raw), .level_o(level_o), .press_o(press_o), .release_o(release_o)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask
   // Reference: pressed = inverted raw seen two edges late; level flips once it has
   // disagreed with the sample for CM consecutive edges.
   logic [W-1:0] e_raw, e_rst_v, m_lvl, m_press, m_rel, m_smp;
   logic         e_rst;
   logic [W-1:0] hist [$];
   int           diff_run [W];
   int           held [W];
   always @(posedge clk) begin
      e_raw <= raw;
      e_rst <= rst;
   end
   task automatic model_step();
      if (e_rst) begin
         hist = {W'(0), W'(0)};
         m_lvl = '0; m_press = '0; m_rel = '0;
         for (int i = 0; i < W; i++) begin diff_run[i] = 0; held[i] = 0; end
      end else begin
         m_smp = hist[1];
         for (int i = 0; i < W; i++) begin
            m_press[i] = 1'b0; m_rel[i] = 1'b0;
            diff_run[i] = (m_smp[i] != m_lvl[i]) ? diff_run[i] + 1 : 0;
            if (diff_run[i] == CM) begin
               m_lvl[i] = ~m_lvl[i];
               m_press[i] = m_lvl[i];
               m_rel[i] = ~m_lvl[i];
               diff_run[i] = 0;
               held[i] = 0;
            end
`ifdef DEBOUNCER_AUTOREPEAT_EN
            else if (m_lvl[i]) begin
               held[i]++;
               if (held[i] == RD || (held[i] > RD && (held[i] - RD) % RP == 0)) m_press[i] = 1'b1;
            end
`endif
         end
         hist.push_front(~e_raw);
         void'(hist.pop_back());
      end
   endtask
   always @(negedge clk) begin
      model_step();
      check("level", level_o, m_lvl);
      check("press", press_o, m_press);
      check("release", release_o, m_rel);
      check("press_and_release", press_o & release_o, 0);
   end
   task automatic wait_pulse(input int ch, input bit rel, input int exp_n, input string tag);
      int n = 0;
      do begin @(negedge clk); n++; end
      while (!(rel ? release_o[ch] : press_o[ch]) && n < 40);
      check(tag, n, exp_n);
   endtask
   initial begin
      logic [W-1:0] seen;
      int           n, hold [W];
      repeat (3) @(negedge clk);
      check("rst_level", level_o, 0);
      check("rst_press", press_o, 0);
      check("rst_release", release_o, 0);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      raw[0] = 1'b0;
      wait_pulse(0, 0, CM + 2, "press0_latency");
      check("press0_level", level_o[0], 1);
      @(negedge clk);
      check("press0_single", press_o[0], 0);
      seen = '0;
      for (int r = 0; r < 4; r++) begin
         raw[1] = 1'b0;
         repeat (5) begin @(negedge clk); seen[1] |= level_o[1] | press_o[1] | release_o[1]; end
         raw[1] = 1'b1;
         repeat (3) begin @(negedge clk); seen[1] |= level_o[1] | press_o[1] | release_o[1]; end
      end
      repeat (10) begin @(negedge clk); seen[1] |= level_o[1] | press_o[1] | release_o[1]; end
      check("glitch_quiet", seen, 0);
      raw[0] = 1'b1;
      wait_pulse(0, 1, CM + 2, "release0_latency");
      check("release0_level", level_o[0], 0);
      repeat (3) @(negedge clk);
      raw = '0;
      n = 0;
      do begin @(negedge clk); n++; end while (press_o == 0 && n < 40);
      check("press_all_latency", n, CM + 2);
      check("press_all", press_o, 4'hF);
      @(negedge clk);
      check("level_all", level_o, 4'hF);
      check("press_all_single", press_o, 0);
      raw = '1;
      n = 0;
      do begin @(negedge clk); n++; end while (release_o == 0 && n < 40);
      check("release_all_latency", n, CM + 2);
      check("release_all", release_o, 4'hF);
      repeat (3) @(negedge clk);
      raw[2] = 1'b0;
      repeat (7) @(negedge clk);
      rst = 1'b1;
      repeat (2) begin
         @(negedge clk);
         check("midrst_out", {level_o, press_o, release_o}, 0);
      end
      rst = 1'b0;
      wait_pulse(2, 0, CM + 2, "press2_after_rst");
      raw[2] = 1'b1;
      repeat (15) @(negedge clk);
`ifdef DEBOUNCER_AUTOREPEAT_EN
      raw[3] = 1'b0;
      wait_pulse(3, 0, CM + 2, "press3_latency");
      for (int t = 1; t <= 60; t++) begin
         @(negedge clk);
         check("repeat_pulse", press_o[3], (t == RD || (t > RD && (t - RD) % RP == 0)));
      end
      raw[3] = 1'b1;
      wait_pulse(3, 1, CM + 2, "release3_latency");
      seen = '0;
      repeat (30) begin @(negedge clk); seen[3] |= press_o[3]; end
      check("repeat_stopped", seen, 0);
`endif
      for (int i = 0; i < W; i++) hold[i] = 0;
      for (int c = 0; c < 800; c++) begin
         for (int i = 0; i < W; i++) begin
            if (hold[i] == 0) begin
               raw[i] = ~raw[i];
               hold[i] = $urandom_range(1, 14);
            end else hold[i]--;
         end
         rst = ($urandom_range(0, 299) == 0);
         @(negedge clk);
      end
      rst = 1'b0;
      raw = '1;
      repeat (20) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
